stage_skid_buffer: RTL and testbench
====================================

# stage_skid_buffer

Two-entry registered skid buffer that terminates the producer side of the pipeline valid/ready handshake. It sits between an upstream pipeline unit and the next stage. The upstream `unit_valid`/data drive `in_valid`/`in_data`, and `in_ready` drives that unit's `output_ready`. It holds a result when downstream stalls, presents it with `out_valid`, and absorbs one extra transfer so that all handshake outputs stay registered at full throughput.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of buffered entries, active-high.
- `in_valid` input 1: upstream offers `in_data` this cycle.
- `in_data` input WIDTH: upstream payload.
- `in_ready` output 1: buffer accepts this cycle; registered.
- `out_valid` output 1: `out_data` holds a valid entry; registered.
- `out_data` output WIDTH: oldest buffered payload; registered.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `count` output 2: entries held (0, 1 or 2); registered.

## Operation
- Transfer in occurs when `in_valid && in_ready`. Transfer out occurs when `out_valid && out_ready`.
- Storage has two registers:
  - `main` drives `out_data`.
  - `skid` holds the second entry.
- FSM states:
  - EMPTY (count 0, in_ready 1, out_valid 0).
  - ONE (count 1, in_ready 1, out_valid 1).
  - TWO (count 2, in_ready 0, out_valid 1).
- Transitions from EMPTY:
  - `in_valid`: main <= in_data, go to ONE.
  - Otherwise stay.
- Transitions from ONE:
  - in and out both: main <= in_data, stay in ONE.
  - in only: skid <= in_data, go to TWO.
  - out only: go to EMPTY.
  - Neither: stay.
- Transitions from TWO:
  - `out_ready`: main <= skid, go to ONE.
  - Otherwise stay.
  - `in_valid` is ignored because `in_ready` is 0.
- `in_ready`, `out_valid` and `count` are decoded from the registered state; they are never combinational from inputs.
- `flush` takes priority over every transition: next state is EMPTY. Any transfer-in presented in the same cycle is dropped. `main`/`skid` contents are unchanged but are invalid.
- Order is strictly FIFO. No entry is duplicated or lost except by `flush` or reset.
- Data registers need no reset. `out_data` is don't-care while `out_valid` is 0.

## Timing
- Reset (`reset_n` low, asynchronous) forces the following immediately, without waiting for a clock edge:
  - state EMPTY.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `count` = 0.
- Release of `reset_n` is synchronized externally. The first active edge after release behaves as EMPTY.
- Reset asserted mid-operation discards both entries. Outputs go to their reset values asynchronously.
- Latency: an entry accepted at edge N appears with `out_valid`=1 after edge N; downstream can take it at edge N+1.
- Throughput: one transfer per cycle sustained while `out_ready` stays high. The buffer holds one entry, state ONE.
- Stall behaviour:
  - `out_ready` low for one cycle while ONE with `in_valid` high fills `skid` (TWO).
  - `in_ready` drops after that edge.
  - The first `out_ready` afterwards returns to ONE, and `in_ready` rises after that edge.
- `out_valid` and `out_data` remain stable while `out_valid && !out_ready`. The buffer never withdraws or changes an offered entry except on `flush` or reset.
- Simultaneous events:
  - Transfer in and out in the same cycle while ONE keeps `count` at 1.
  - `flush` together with any transfer yields `count` 0 next cycle.

## Test plan
- Reset and release:
  - Stimulus: hold `reset_n` low mid-cycle while TWO.
  - Response: immediately `in_ready`=1, `out_valid`=0, `count`=0.
  - After release, `in_valid`=1 with data 0xA5 gives `out_valid`=1 with `out_data`=0xA5 one edge later.
- Streaming:
  - Stimulus: `out_ready`=1 constantly, inputs 1,2,3,4,5 on consecutive cycles.
  - Response: outputs 1..5 on consecutive cycles, `count` stays 1, `in_ready` never drops.
- Fill and stall:
  - Stimulus: `out_ready`=0, inputs 0x10, 0x20, 0x30 offered back to back.
  - Response: 0x10 and 0x20 accepted, `count`=2, `in_ready`=0.
  - 0x30 is held upstream; `out_data` stays 0x10 throughout the stall.
- Drain:
  - Stimulus: from that state, raise `out_ready`.
  - Response: 0x10, then 0x20, then 0x30 (accepted once `in_ready` returns to 1) in order, with no duplicates.
  - `count` sequence 2,1,1,... and EMPTY after the last entry.
- Flush:
  - Stimulus: assert `flush` while TWO and `in_valid`=1 with 0x77.
  - Response: next cycle `count`=0 and `out_valid`=0. 0x77 is never output.
- Randomized backpressure:
  - Stimulus: random `in_valid`/`out_ready` for 10k cycles against a scoreboard.
  - Response: exact FIFO order, and `count` never exceeds 2.

Source files
------------

// File: rtl/stage_skid_buffer.sv
// -----------------------------------------------------------------------------
// stage_skid_buffer
//
// Two-entry registered skid buffer that ends the producer side of a pipeline
// valid/ready link. It holds a result while the next stage stalls and absorbs
// one extra transfer, so every handshake output comes straight from the state
// register and the link still runs at one transfer per cycle.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge exactly
// when valid && ready are both high in the cycle before that edge. A producer
// that raises valid keeps valid and data stable until the transfer happens.
// This buffer never withdraws or changes an offered out_data except on flush
// or reset.
//
// Ports
//   clk       : single clock, rising edge
//   reset_n   : asynchronous active-low reset (release synchronized outside)
//   flush     : synchronous clear of all buffered entries, active-high
//   in_valid  : upstream offers in_data this cycle
//   in_data   : upstream payload, WIDTH bits
//   in_ready  : buffer can accept this cycle (state decode, not from inputs)
//   out_valid : out_data holds a valid entry (state decode)
//   out_data  : oldest buffered payload (the main register)
//   out_ready : downstream accepts out_data this cycle
//   count     : number of entries held, 0..2 (equals the state encoding)
// -----------------------------------------------------------------------------
module stage_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // The encoding is chosen so the state value is the occupancy; count is
    // therefore a direct view of the FSM state for checkers and debug.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Data-path load selects produced by the next-state logic.
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid_in;

    logic             xfer_in;
    logic             xfer_out;

    // Handshake outputs decode only the registered state.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign count     = state;
    assign out_data  = main_q;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;

        if (flush) begin
            // Flush wins over everything; a transfer-in this cycle is dropped
            // and the data registers keep stale, now-invalid contents.
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        // Replace the entry being taken; occupancy stays 1.
                        load_main_in = 1'b1;
                    end else if (xfer_in) begin
                        load_skid_in = 1'b1;
                        state_next   = TWO;
                    end else if (xfer_out) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (xfer_out) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Payload registers carry no reset: their content only matters while the
    // state says it is valid.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid_in) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: tb/tb_stage_skid_buffer.sv
module tb_stage_skid_buffer;

  localparam int W = 8;

  // clock / reset block
  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage_skid_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] c, input logic ir, input logic ov);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
  endtask

  initial begin
    logic [W-1:0] sent;
    logic         exp_ov;
    logic         exp_ir;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk_state("reset", 2'd0, 1'b1, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_state("idle_after_release", 2'd0, 1'b1, 1'b0);

    // streaming: 1..5 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      chk_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1);
      chk($sformatf("stream%0d.data", i), 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_end", 2'd0, 1'b1, 1'b0);

    // fill and stall: 0x10, 0x20 taken, 0x30 held upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    tick();
    chk_state("fill1", 2'd1, 1'b1, 1'b1);
    chk("fill1.data", 32'(out_data), 32'h10);
    in_data = 8'h20;
    tick();
    chk_state("fill2", 2'd2, 1'b0, 1'b1);
    chk("fill2.data", 32'(out_data), 32'h10);
    in_data = 8'h30;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("stall%0d", i), 2'd2, 1'b0, 1'b1);
      chk($sformatf("stall%0d.data", i), 32'(out_data), 32'h10);
    end

    // drain: 0x20 then 0x30, then empty
    out_ready = 1'b1;
    tick();
    chk_state("drain1", 2'd1, 1'b1, 1'b1);
    chk("drain1.data", 32'(out_data), 32'h20);
    tick();
    chk_state("drain2", 2'd1, 1'b1, 1'b1);
    chk("drain2.data", 32'(out_data), 32'h30);
    in_valid = 1'b0;
    tick();
    chk_state("drain_end", 2'd0, 1'b1, 1'b0);

    // flush while TWO with a transfer-in offered (0x77 must vanish)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h40;
    tick();
    in_data = 8'h50;
    tick();
    chk_state("pre_flush", 2'd2, 1'b0, 1'b1);
    flush   = 1'b1;
    in_data = 8'h77;
    tick();
    chk_state("flush", 2'd0, 1'b1, 1'b0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_state("post_flush", 2'd0, 1'b1, 1'b0);

    // flush from ONE together with in and out transfers
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_data = 8'h77;
    flush   = 1'b1;
    tick();
    chk_state("flush_one", 2'd0, 1'b1, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // asynchronous reset mid-cycle while TWO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h60;
    tick();
    in_data = 8'h61;
    tick();
    chk_state("pre_reset", 2'd2, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_state("async_reset", 2'd0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    chk_state("after_reset", 2'd1, 1'b1, 1'b1);
    chk("after_reset.data", 32'(out_data), 32'hA5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_state("after_reset_drain", 2'd0, 1'b1, 1'b0);

    // randomized backpressure against the scoreboard
    exp_q.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = W'($urandom_range(0, 255));
      exp_ov = (exp_q.size() > 0);
      exp_ir = (exp_q.size() < 2);
      chk("rand.count", 32'(count), 32'(exp_q.size()));
      chk("rand.in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rand.out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) chk("rand.data", 32'(out_data), 32'(exp_q[0]));
      if (exp_ov && out_ready) sent = exp_q.pop_front();
      if (in_valid && exp_ir) exp_q.push_back(in_data);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk("flushout.valid", 32'(out_valid), 32'h1);
      chk("flushout.data", 32'(out_data), 32'(exp_q[0]));
      sent = exp_q.pop_front();
      tick();
    end
    chk_state("final", 2'd0, 1'b1, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
